// File: rtl/stump_reg_bank_if.sv
// ============================================================================
//  Module      : stump_reg_bank_if
//  Description : Port bundle for the Stump register bank: write-back, PC
//                increment, three read ports and the condition-code register.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface stump_reg_bank_if;
  logic        write_en;
  logic [2:0]  write_addr;
  logic [15:0] write_data;
  logic        pc_inc;
  logic [2:0]  read_addr_A;
  logic [15:0] read_data_A;
  logic [2:0]  read_addr_B;
  logic [15:0] read_data_B;
  logic [2:0]  read_addr_C;
  logic [15:0] read_data_C;
  logic [15:0] pc_out;
  logic        cc_en;
  logic [3:0]  cc_in;
  logic [3:0]  cc_out;

  // Datapath/control side: issues writes and read selects, consumes read data.
  modport master (
    output write_en, write_addr, write_data, pc_inc,
    output read_addr_A, read_addr_B, read_addr_C,
    output cc_en, cc_in,
    input  read_data_A, read_data_B, read_data_C, pc_out, cc_out
  );

  // Register bank side.
  modport slave (
    input  write_en, write_addr, write_data, pc_inc,
    input  read_addr_A, read_addr_B, read_addr_C,
    input  cc_en, cc_in,
    output read_data_A, read_data_B, read_data_C, pc_out, cc_out
  );
endinterface

`default_nettype wire

// File: rtl/stump_reg_bank.sv
// ============================================================================
//  Module      : stump_reg_bank
//  Description : Stump R0..R7 register file (R0 = zero, R7 = PC) with three
//                combinational read ports and the {N,Z,V,C} register.
//                Optional write-through forwarding: STUMP_REG_BYPASS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stump_reg_bank #(
  parameter logic [15:0] PC_RESET = 16'h0000,
  parameter logic [3:0]  CC_RESET = 4'b0000
) (
  input  wire logic         clk,
  input  wire logic         rst,
  stump_reg_bank_if.slave   bus
);

  localparam logic [2:0] c_zero_addr = 3'd0;
  localparam logic [2:0] c_pc_addr   = 3'd7;

  logic [15:0] r_gpr [1:6];
  logic [15:0] r_pc;
  logic [3:0]  r_cc;

  logic [15:0] w_view [0:7];
  logic        w_pc_write;
  logic        w_fwd_A;
  logic        w_fwd_B;
  logic        w_fwd_C;
  logic        w_fwd_pc;
  logic        w_fwd_cc;

  assign w_pc_write = bus.write_en && (bus.write_addr == c_pc_addr);

  // General-purpose registers R1..R6; address 0 has no storage behind it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i <= 6; i++) begin
        r_gpr[i] <= 16'h0000;
      end
    end else if (bus.write_en) begin
      for (int i = 1; i <= 6; i++) begin
        if (bus.write_addr == 3'(i)) begin
          r_gpr[i] <= bus.write_data;
        end
      end
    end
  end

  // An explicit write to R7 wins over the increment in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= PC_RESET;
    end else if (w_pc_write) begin
      r_pc <= bus.write_data;
    end else if (bus.pc_inc) begin
      r_pc <= r_pc + 16'h0001;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cc <= CC_RESET;
    end else if (bus.cc_en) begin
      r_cc <= bus.cc_in;
    end
  end

  always_comb begin
    w_view[0] = 16'h0000;
    for (int i = 1; i <= 6; i++) begin
      w_view[i] = r_gpr[i];
    end
    w_view[7] = r_pc;
  end

`ifdef STUMP_REG_BYPASS_EN
  // Forward the in-flight write; R0 is never a forwarding target.
  assign w_fwd_A  = bus.write_en && (bus.write_addr != c_zero_addr) &&
                    (bus.write_addr == bus.read_addr_A);
  assign w_fwd_B  = bus.write_en && (bus.write_addr != c_zero_addr) &&
                    (bus.write_addr == bus.read_addr_B);
  assign w_fwd_C  = bus.write_en && (bus.write_addr != c_zero_addr) &&
                    (bus.write_addr == bus.read_addr_C);
  assign w_fwd_pc = w_pc_write;
  assign w_fwd_cc = bus.cc_en;
`else
  assign w_fwd_A  = 1'b0;
  assign w_fwd_B  = 1'b0;
  assign w_fwd_C  = 1'b0;
  assign w_fwd_pc = 1'b0;
  assign w_fwd_cc = 1'b0;
`endif

  assign bus.read_data_A = w_fwd_A  ? bus.write_data : w_view[bus.read_addr_A];
  assign bus.read_data_B = w_fwd_B  ? bus.write_data : w_view[bus.read_addr_B];
  assign bus.read_data_C = w_fwd_C  ? bus.write_data : w_view[bus.read_addr_C];
  assign bus.pc_out      = w_fwd_pc ? bus.write_data : r_pc;
  assign bus.cc_out      = w_fwd_cc ? bus.cc_in      : r_cc;

endmodule

`default_nettype wire
